// File: rtl/fixed_pkg.sv
// Shared fixed-point types and constants for the Q7.20 arithmetic blocks.
package fixed_pkg;

  localparam int unsigned FIXED_INT_BITS  = 7;
  localparam int unsigned FIXED_FRAC_BITS = 20;
  localparam int unsigned FIXED_W         = FIXED_INT_BITS + FIXED_FRAC_BITS;

  typedef logic signed [FIXED_W-1:0] fixed_t;

  typedef enum logic {
    RND_TRUNC   = 1'b0,
    RND_HALF_UP = 1'b1
  } round_mode_e;

  localparam fixed_t FIXED_ONE = fixed_t'(1) << FIXED_FRAC_BITS;
  localparam fixed_t FIXED_MAX = {1'b0, {(FIXED_W-1){1'b1}}};
  localparam fixed_t FIXED_MIN = {1'b1, {(FIXED_W-1){1'b0}}};

endpackage

// File: rtl/fixed_round_sat.sv
// Combinational rounding, fraction shift, overflow detect and optional clamp
// of a full-width product. Saturation is enabled by defining FIXED_MULT_SAT_EN.
module fixed_round_sat
  import fixed_pkg::*;
#(
  parameter int unsigned W         = FIXED_W,
  parameter int unsigned FRAC_BITS = FIXED_FRAC_BITS,
  parameter int unsigned ROUND     = 32'(RND_TRUNC)
) (
  input  logic signed [2*W-1:0] prod,
  output logic signed [W-1:0]   p_c,
  output logic                  ovf_c
);

  localparam int unsigned QW      = 2*W + 1;
  localparam bit          HALF_UP = (ROUND == 32'(RND_HALF_UP));
  localparam logic signed [QW-1:0] RND_ADD =
    HALF_UP ? (QW'(1) << (FRAC_BITS-1)) : QW'(0);

  logic signed [QW-1:0] q;
  logic signed [QW-1:0] r;

  // Result fits iff every bit from the W-bit sign position upward agrees.
  always_comb begin
    q     = QW'(prod) + RND_ADD;
    r     = q >>> FRAC_BITS;
    ovf_c = !((&r[QW-1:W-1]) || !(|r[QW-1:W-1]));
    p_c   = r[W-1:0];
`ifdef FIXED_MULT_SAT_EN
    if (ovf_c) begin
      p_c = r[QW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`endif
  end

endmodule

// File: rtl/fixed_mult_pipe.sv
// Three-stage pipelined signed fixed-point multiplier with valid/ready, tag
// pass-through and overflow flag. Define FIXED_MULT_SAT_EN for saturating output.
module fixed_mult_pipe
  import fixed_pkg::*;
#(
  parameter int unsigned INT_BITS  = FIXED_INT_BITS,
  parameter int unsigned FRAC_BITS = FIXED_FRAC_BITS,
  parameter int unsigned ROUND     = 32'(RND_TRUNC),
  parameter int unsigned TAG_W     = 8,
  localparam int unsigned W        = INT_BITS + FRAC_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_a,
  input  logic signed [W-1:0] in_b,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_p,
  output logic [TAG_W-1:0]    out_tag,
  output logic                out_ovf
);

  localparam int unsigned PW = 2*W;

  logic                 adv_c;
  logic                 s1_valid;
  logic signed [W-1:0]  s1_a;
  logic signed [W-1:0]  s1_b;
  logic [TAG_W-1:0]     s1_tag;
  logic                 s2_valid;
  logic signed [PW-1:0] s2_p;
  logic [TAG_W-1:0]     s2_tag;
  logic signed [W-1:0]  rs_p_c;
  logic                 rs_ovf_c;

  // Whole pipe advances together; bubbles travel with the beats.
  assign adv_c    = !out_valid || out_ready;
  assign in_ready = adv_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_p     <= '0;
      out_tag   <= '0;
      out_ovf   <= 1'b0;
    end else if (adv_c) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_p   <= rs_p_c;
        out_tag <= s2_tag;
        out_ovf <= rs_ovf_c;
      end
    end
  end

  // Datapath registers only load alongside a valid beat.
  always_ff @(posedge clk) begin
    if (adv_c && in_valid) begin
      s1_a   <= in_a;
      s1_b   <= in_b;
      s1_tag <= in_tag;
    end
    if (adv_c && s1_valid) begin
      s2_p   <= PW'(s1_a) * PW'(s1_b);
      s2_tag <= s1_tag;
    end
  end

  fixed_round_sat #(
    .W         (W),
    .FRAC_BITS (FRAC_BITS),
    .ROUND     (ROUND)
  ) u_round (
    .prod  (s2_p),
    .p_c   (rs_p_c),
    .ovf_c (rs_ovf_c)
  );

endmodule

// File: tb/tb_fixed_mult_pipe.sv
// Bench for fixed_mult_pipe: truncating and rounding instances driven in lockstep
// and scoreboarded against an integer model of the Q7.20 product.
module tb_fixed_mult_pipe;
  import fixed_pkg::*;

  typedef struct {
    logic [FIXED_W-1:0] p;
    logic               ovf;
    logic [7:0]         tag;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  fixed_t             in_a;
  fixed_t             in_b;
  logic [7:0]         in_tag;
  logic               out_ready;
  logic               in_ready0, in_ready1;
  logic               out_valid0, out_valid1;
  logic [FIXED_W-1:0] out_p0, out_p1;
  logic [7:0]         out_tag0, out_tag1;
  logic               out_ovf0, out_ovf1;

  int tests = 0;
  int fails = 0;

  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] tag_log[$];
  bit log_en = 1'b0;

  bit                 hold = 1'b0;
  logic [FIXED_W-1:0] held_p;
  logic [7:0]         held_tag;
  logic               held_ovf;
  exp_t               me;
  bit                 mo;

`ifdef FIXED_MULT_SAT_EN
  localparam logic [FIXED_W-1:0] EXP_40SQ  = 27'h3FFFFFF;
  localparam logic [FIXED_W-1:0] EXP_MINSQ = 27'h3FFFFFF;
`else
  localparam logic [FIXED_W-1:0] EXP_40SQ  = 27'h4000000;
  localparam logic [FIXED_W-1:0] EXP_MINSQ = 27'h0000000;
`endif

  always #5 clk = ~clk;

  fixed_mult_pipe #(.INT_BITS(7), .FRAC_BITS(20), .ROUND(0), .TAG_W(8)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid0),
    .out_ready(out_ready), .out_p(out_p0), .out_tag(out_tag0), .out_ovf(out_ovf0)
  );

  fixed_mult_pipe #(.INT_BITS(7), .FRAC_BITS(20), .ROUND(1), .TAG_W(8)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid1),
    .out_ready(out_ready), .out_p(out_p1), .out_tag(out_tag1), .out_ovf(out_ovf1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Exact product, optional half-LSB bias, floor shift, then range test.
  function automatic logic [FIXED_W-1:0] model_p(input fixed_t a, input fixed_t b,
                                                 input bit rnd, output bit ovf);
    longint p, r, maxv, minv;
    maxv = (longint'(1) << (FIXED_W-1)) - 1;
    minv = -(longint'(1) << (FIXED_W-1));
    p = longint'(a) * longint'(b);
    if (rnd) p = p + (longint'(1) << (FIXED_FRAC_BITS-1));
    r = p >>> FIXED_FRAC_BITS;
    ovf = (r > maxv) || (r < minv);
`ifdef FIXED_MULT_SAT_EN
    if (ovf) return (r > 0) ? FIXED_MAX : FIXED_MIN;
`endif
    return FIXED_W'(r);
  endfunction

  function automatic fixed_t rand_operand();
    fixed_t v;
    case ($urandom_range(0, 15))
      0: return FIXED_MAX;
      1: return FIXED_MIN;
      2: return '0;
      3: return FIXED_ONE;
      4: return -FIXED_ONE;
      5: return fixed_t'($urandom_range(0, 3)) - fixed_t'(2);
      default: begin
        v = FIXED_W'($urandom);
        return v >>> $urandom_range(0, 26);
      end
    endcase
  endfunction

  // Scoreboard: every handshake that the next rising edge will complete.
  always @(negedge clk) begin
    if (reset) begin
      q0.delete();
      q1.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("stall_valid", 64'(out_valid0), 64'd1);
        check("stall_p", 64'(out_p0), 64'(held_p));
        check("stall_tag", 64'(out_tag0), 64'(held_tag));
        check("stall_ovf", 64'(out_ovf0), 64'(held_ovf));
      end
      hold     = out_valid0 && !out_ready;
      held_p   = out_p0;
      held_tag = out_tag0;
      held_ovf = out_ovf0;
      if (out_valid0 && out_ready) begin
        if (log_en) tag_log.push_back(out_tag0);
        if (q0.size() == 0) begin
          tests++; fails++;
          $display("FAIL r0_spurious: got tag 0x%0h, expected no output", out_tag0);
        end else begin
          me = q0.pop_front();
          check("r0_p", 64'(out_p0), 64'(me.p));
          check("r0_ovf", 64'(out_ovf0), 64'(me.ovf));
          check("r0_tag", 64'(out_tag0), 64'(me.tag));
        end
      end
      if (out_valid1 && out_ready) begin
        if (q1.size() == 0) begin
          tests++; fails++;
          $display("FAIL r1_spurious: got tag 0x%0h, expected no output", out_tag1);
        end else begin
          me = q1.pop_front();
          check("r1_p", 64'(out_p1), 64'(me.p));
          check("r1_ovf", 64'(out_ovf1), 64'(me.ovf));
          check("r1_tag", 64'(out_tag1), 64'(me.tag));
        end
      end
      if (in_valid && in_ready0) begin
        me.p = model_p(in_a, in_b, 1'b0, mo); me.ovf = mo; me.tag = in_tag;
        q0.push_back(me);
      end
      if (in_valid && in_ready1) begin
        me.p = model_p(in_a, in_b, 1'b1, mo); me.ovf = mo; me.tag = in_tag;
        q1.push_back(me);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
  endtask

  // Single beat into an empty pipe: pins the model, the DUT value and latency.
  task automatic directed(input string name, input fixed_t a, input fixed_t b,
                          input logic [FIXED_W-1:0] e0, input logic [FIXED_W-1:0] e1,
                          input logic eovf);
    int lat;
    bit o;
    logic [FIXED_W-1:0] m;
    m = model_p(a, b, 1'b0, o);
    check({name, "_model_trunc"}, 64'(m), 64'(e0));
    check({name, "_model_ovf"}, 64'(o), 64'(eovf));
    m = model_p(a, b, 1'b1, o);
    check({name, "_model_rnd"}, 64'(m), 64'(e1));
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = a; in_b = b; in_tag = 8'hA5; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid0 && lat < 8);
    check({name, "_latency"}, 64'(lat), 64'd3);
    check({name, "_p_trunc"}, 64'(out_p0), 64'(e0));
    check({name, "_p_rnd"}, 64'(out_p1), 64'(e1));
    check({name, "_ovf_trunc"}, 64'(out_ovf0), 64'(eovf));
    check({name, "_ovf_rnd"}, 64'(out_ovf1), 64'(eovf));
    check({name, "_tag"}, 64'(out_tag0), 64'hA5);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int next_tag;
    int acc;
    int cyc;
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid0), 64'd0);
    check("rst_out_p", 64'(out_p0), 64'd0);
    check("rst_out_tag", 64'(out_tag0), 64'd0);
    check("rst_out_ovf", 64'(out_ovf0), 64'd0);
    check("rst_in_ready", 64'(in_ready0), 64'd1);

    directed("mul_1p5x2", 27'h0180000, 27'h0200000, 27'h0300000, 27'h0300000, 1'b0);
    directed("mul_m1p5x2", 27'h7E80000, 27'h0200000, 27'h7D00000, 27'h7D00000, 1'b0);
    directed("mul_40x40", 27'h2800000, 27'h2800000, EXP_40SQ, EXP_40SQ, 1'b1);
    directed("mul_minxmin", FIXED_MIN, FIXED_MIN, EXP_MINSQ, EXP_MINSQ, 1'b1);
    directed("lsb_x_half", 27'h0000001, 27'h0080000, 27'h0000000, 27'h0000001, 1'b0);
    directed("mlsb_x_half", 27'h7FFFFFF, 27'h0080000, 27'h7FFFFFF, 27'h0000000, 1'b0);
    directed("x_times_0", 27'h1234567, 27'h0000000, 27'h0000000, 27'h0000000, 1'b0);

    // Backpressure: four tagged beats against a stalled consumer.
    idle(5);
    next_tag = 1;
    tag_log.delete();
    log_en = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      out_ready = (c >= 5);
      in_valid  = (next_tag <= 4);
      in_tag    = 8'(next_tag);
      in_a      = rand_operand();
      in_b      = rand_operand();
      @(negedge clk);
      if (c == 3 || c == 4) check("full_in_ready_low", 64'(in_ready0), 64'd0);
      if (in_valid && in_ready0) next_tag++;
    end
    log_en = 1'b0;
    check("tag_count", 64'(tag_log.size()), 64'd4);
    for (int i = 0; i < tag_log.size() && i < 4; i++)
      check("tag_order", 64'(tag_log[i]), 64'(i + 1));

    // Full-rate streaming.
    idle(5);
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; out_ready = 1'b1;
      in_a = rand_operand(); in_b = rand_operand(); in_tag = 8'($urandom);
      @(negedge clk);
      check("thru_in_ready", 64'(in_ready0), 64'd1);
      if (c >= 3) check("thru_out_valid", 64'(out_valid0), 64'd1);
    end

    // Random traffic on both sides.
    idle(5);
    acc = 0;
    cyc = 0;
    while (acc < 10000 && cyc < 40000) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_a = rand_operand(); in_b = rand_operand(); in_tag = 8'($urandom);
      @(negedge clk);
      if (in_valid && in_ready0) acc++;
      cyc++;
    end
    check("rand_beats", 64'(acc), 64'd10000);

    // Reset with the pipe full and both handshakes attempted.
    idle(5);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_tag = 8'(16 + i);
      in_a = rand_operand(); in_b = rand_operand();
    end
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid0), 64'd0);
    check("flush_out_valid_rnd", 64'(out_valid1), 64'd0);
    check("flush_out_p", 64'(out_p0), 64'd0);
    check("flush_out_tag", 64'(out_tag0), 64'd0);
    check("flush_in_ready", 64'(in_ready0), 64'd1);
    directed("post_reset", FIXED_ONE, FIXED_ONE, FIXED_ONE, FIXED_ONE, 1'b0);

    idle(8);
    @(negedge clk);
    check("drain_q_trunc", 64'(q0.size()), 64'd0);
    check("drain_q_rnd", 64'(q1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
